// File: rtl/vga_capture.sv
// VGA receive monitor: samples hsync/vsync/RGB, recovers pixel coordinates,
// checks sync timing against the configured mode and exposes status on the CPU bus.
module vga_capture #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  input  logic        we,
  input  logic        rd,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [11:0] pixel_color,
  output logic        locked
);

  localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0] H_TOTAL_W = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  localparam logic [10:0] V_TOTAL_W = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [9:0]  H_ACT_LO  = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_ACT_HI  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_ACT_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_ACT_HI  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  CNT_MAX   = 10'd1023;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_GOOD1    = 2'd1,
    S_LOCKED   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        hs_q, hs_dly_q, vs_q, vs_dly_q;
  logic [11:0] rgb_q;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;
  logic [31:0] frame_q, frame_d;
  logic [9:0]  probe_x_q, probe_x_d;
  logic [8:0]  probe_y_q, probe_y_d;
  logic        probe_vld_q, probe_vld_d;
  logic [11:0] probe_col_q, probe_col_d;
  logic        pv_q, pv_d, locked_q, locked_d;
  logic [9:0]  px_q, px_d;
  logic [8:0]  py_q, py_d;
  logic [11:0] pc_q, pc_d;

  logic        hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
  logic [10:0] hcnt_inc_s, vcnt_inc_s, vs_width_s;
  logic        h_err_ev_s, v_err_ev_s, err_ev_s, active_s;
  logic [9:0]  xoff_s, yoff_s;
  logic        sts_wr_s, frame_wr_s, xy_wr_s;
  logic        unused_s;

  assign hs_fall_s  = hs_dly_q & ~hs_q;
  assign hs_rise_s  = ~hs_dly_q & hs_q;
  assign vs_fall_s  = vs_dly_q & ~vs_q;
  assign vs_rise_s  = ~vs_dly_q & vs_q;
  assign hcnt_inc_s = {1'b0, hcnt_q} + 11'd1;
  assign vcnt_inc_s = {1'b0, vcnt_q} + 11'd1;
  // A vsync rise on the same cycle as an hsync fall counts that line too.
  assign vs_width_s = hs_fall_s ? vcnt_inc_s : {1'b0, vcnt_q};

  assign h_err_ev_s = (hs_rise_s && (hcnt_inc_s != H_SYNC_W)) ||
                      (hs_fall_s && h_seen_q && (hcnt_inc_s != H_TOTAL_W));
  assign v_err_ev_s = (vs_rise_s && (vs_width_s != V_SYNC_W)) ||
                      (vs_fall_s && v_seen_q && (vcnt_inc_s != V_TOTAL_W));
  assign err_ev_s   = h_err_ev_s | v_err_ev_s;

  assign sts_wr_s   = we && (addr[3:2] == 2'd0);
  assign frame_wr_s = we && (addr[3:2] == 2'd1);
  assign xy_wr_s    = we && (addr[3:2] == 2'd2);

  assign unused_s = ^{addr[31:4], addr[1:0], data_in[31:25], data_in[15:10], data_in[0], yoff_s[9]};

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (hs_fall_s) begin
      hcnt_d = 10'd0;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 10'd1;
    end else begin
      hcnt_d = hcnt_q;
    end
    if (vs_fall_s) begin
      vcnt_d = 10'd0;
    end else if (hs_fall_s && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end else begin
      vcnt_d = vcnt_q;
    end
  end

  // Next counter values line up with the colour held in rgb_q.
  assign active_s = (hcnt_d >= H_ACT_LO) && (hcnt_d <= H_ACT_HI) &&
                    (vcnt_d >= V_ACT_LO) && (vcnt_d <= V_ACT_HI);
  assign xoff_s   = hcnt_d - H_ACT_LO;
  assign yoff_s   = vcnt_d - V_ACT_LO;

  always_comb begin
    state_d = state_q;
    if (err_ev_s) begin
      state_d = S_UNLOCKED;
    end else begin
      case (state_q)
        S_UNLOCKED: state_d = vs_fall_s ? S_GOOD1 : S_UNLOCKED;
        S_GOOD1:    state_d = vs_fall_s ? S_LOCKED : S_GOOD1;
        S_LOCKED:   state_d = S_LOCKED;
        default:    state_d = S_UNLOCKED;
      endcase
    end
  end

  always_comb begin
    h_seen_d    = h_seen_q | hs_fall_s;
    v_seen_d    = v_seen_q | vs_fall_s;
    h_err_d     = h_err_ev_s | (h_err_q & ~(sts_wr_s & data_in[1]));
    v_err_d     = v_err_ev_s | (v_err_q & ~(sts_wr_s & data_in[2]));
    frame_d     = frame_q;
    probe_x_d   = probe_x_q;
    probe_y_d   = probe_y_q;
    probe_vld_d = probe_vld_q;
    probe_col_d = probe_col_q;
    locked_d    = (state_d == S_LOCKED);
    pv_d        = (state_d == S_LOCKED) && active_s;
    px_d        = px_q;
    py_d        = py_q;
    pc_d        = pc_q;
    if (frame_wr_s) begin
      frame_d = 32'd0;
    end else if (vs_fall_s && (state_q == S_LOCKED)) begin
      frame_d = frame_q + 32'd1;
    end else begin
      frame_d = frame_q;
    end
    if (xy_wr_s) begin
      probe_x_d   = data_in[9:0];
      probe_y_d   = data_in[24:16];
      probe_vld_d = 1'b0;
    end else if (pv_q && (px_q == probe_x_q) && (py_q == probe_y_q)) begin
      probe_col_d = pc_q;
      probe_vld_d = 1'b1;
    end else begin
      probe_vld_d = probe_vld_q;
    end
    if (active_s) begin
      px_d = xoff_s;
      py_d = yoff_s[8:0];
      pc_d = rgb_q;
    end else begin
      px_d = px_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q        <= 1'b1;
      hs_dly_q    <= 1'b1;
      vs_q        <= 1'b1;
      vs_dly_q    <= 1'b1;
      rgb_q       <= 12'd0;
      hcnt_q      <= 10'd0;
      vcnt_q      <= 10'd0;
      h_seen_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      state_q     <= S_UNLOCKED;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      frame_q     <= 32'd0;
      probe_x_q   <= 10'd0;
      probe_y_q   <= 9'd0;
      probe_vld_q <= 1'b0;
      probe_col_q <= 12'd0;
      locked_q    <= 1'b0;
      pv_q        <= 1'b0;
      px_q        <= 10'd0;
      py_q        <= 9'd0;
      pc_q        <= 12'd0;
    end else begin
      hs_q        <= hsync_in;
      hs_dly_q    <= hs_q;
      vs_q        <= vsync_in;
      vs_dly_q    <= vs_q;
      rgb_q       <= {r_in, g_in, b_in};
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      h_seen_q    <= h_seen_d;
      v_seen_q    <= v_seen_d;
      state_q     <= state_d;
      h_err_q     <= h_err_d;
      v_err_q     <= v_err_d;
      frame_q     <= frame_d;
      probe_x_q   <= probe_x_d;
      probe_y_q   <= probe_y_d;
      probe_vld_q <= probe_vld_d;
      probe_col_q <= probe_col_d;
      locked_q    <= locked_d;
      pv_q        <= pv_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pc_q        <= pc_d;
    end
  end

  always_comb begin
    data_out = 32'd0;
    if (rd) begin
      case (addr[3:2])
        2'd0:    data_out = {29'd0, v_err_q, h_err_q, locked_q};
        2'd1:    data_out = frame_q;
        2'd2:    data_out = {7'd0, probe_y_q, 6'd0, probe_x_q};
        2'd3:    data_out = {probe_vld_q, 19'd0, probe_col_q};
        default: data_out = 32'd0;
      endcase
    end else begin
      data_out = 32'd0;
    end
  end

  assign pixel_valid = pv_q;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign pixel_color = pc_q;
  assign locked      = locked_q;

endmodule
